// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter shared types and constants.
// State enum, data width, INT_MIN and requester id type.
package adder_arb_pkg;

  localparam int DW = 32;
  localparam logic [DW-1:0] INT_MIN = 32'h8000_0000;
  localparam int ID_W = 1;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [1:0] {
    IDLE,
    NEG,
    ADD,
    RESP
  } state_t;

endpackage

// File: rtl/adder_arbiter_addition.sv
// addition: shared 32-bit adder, no carry-in.
// Ports: in1, in2 operands; s sum; overflow signed overflow.
import adder_arb_pkg::*;

module addition (
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  output logic [DW-1:0] s,
  output logic          overflow
);

  assign s = in1 + in2;

  // Same-sign operands producing a different-sign sum.
  assign overflow = (in1[DW-1] == in2[DW-1]) &
                    (s[DW-1] != in1[DW-1]);

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin share of one adder between two requesters.
// Ports: clock/reset_n, req0/req1 valid-ready ops, rsp valid-ready result.
import adder_arb_pkg::*;

module adder_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_sub,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_sub,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_sum,
  output logic          rsp_overflow
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          sub_q;
  logic          bmin_q;
  id_t           id_q;
  id_t           last_grant;

  logic          idle;
  logic          gnt_any;
  id_t           gnt_id;
  logic          accept;
  logic [DW-1:0] gnt_a;
  logic [DW-1:0] gnt_b;
  logic          gnt_sub;

  logic [DW-1:0] add_in1;
  logic [DW-1:0] add_in2;
  logic [DW-1:0] add_s;
  logic          add_ovf;

  assign idle    = (state_q == IDLE);
  assign gnt_any = req0_valid | req1_valid;

  always_comb begin
    gnt_id = id_t'(req1_valid);
    if (req0_valid & req1_valid) begin
      gnt_id = FIXED_PRIORITY ? id_t'(0) : ~last_grant;
    end
  end

  // Ready is gated by reset so nothing is taken while reset is held.
  assign req0_ready = reset_n & idle & gnt_any & ~gnt_id[0];
  assign req1_ready = reset_n & idle & gnt_any & gnt_id[0];
  assign accept     = req0_ready | req1_ready;

  assign gnt_a   = gnt_id[0] ? req1_a   : req0_a;
  assign gnt_b   = gnt_id[0] ? req1_b   : req0_b;
  assign gnt_sub = gnt_id[0] ? req1_sub : req0_sub;

  // NEG pass forms -b as ~b + 1 since the adder has no carry-in.
  assign add_in1 = (state_q == NEG) ? ~b_q    : a_q;
  assign add_in2 = (state_q == NEG) ? DW'(1)  : b_q;

  addition u_add (
    .in1      (add_in1),
    .in2      (add_in2),
    .s        (add_s),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = gnt_sub ? NEG : ADD;
      NEG:  state_d = ADD;
      ADD:  state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      bmin_q       <= 1'b0;
      id_q         <= '0;
      last_grant   <= id_t'(1);
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= gnt_a;
            b_q        <= gnt_b;
            sub_q      <= gnt_sub;
            bmin_q     <= 1'b0;
            id_q       <= gnt_id;
            last_grant <= gnt_id;
          end
        end
        NEG: begin
          b_q    <= add_s;
          bmin_q <= (b_q == INT_MIN);
        end
        ADD: begin
          rsp_sum   <= add_s;
          // -INT_MIN wraps to INT_MIN, so a - INT_MIN
          // overflows exactly when a is non-negative.
          rsp_overflow <= (sub_q & bmin_q) ? ~a_q[DW-1]
                                           : add_ovf;
          rsp_id    <= id_q[0];
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed bench with a cycle scoreboard model.
// Drives both instances (round-robin and fixed priority).
module tb_adder_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        rsp_valid, rsp_id, rsp_overflow;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_sum;

  logic        f_v0 = 1'b0, f_v1 = 1'b0;
  logic        f_r0, f_r1, f_rv, f_id, f_ovf;
  logic [31:0] f_sum;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  adder_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_overflow(rsp_overflow)
  );

  adder_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(f_v0), .req0_ready(f_r0),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(f_v1), .req1_ready(f_r1),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(f_rv), .rsp_ready(1'b1),
    .rsp_id(f_id), .rsp_sum(f_sum),
    .rsp_overflow(f_ovf)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input bit sub,
                                 output logic [31:0] s,
                                 output bit o);
    longint r;
    r = sub ? longint'($signed(a)) - longint'($signed(b))
            : longint'($signed(a)) + longint'($signed(b));
    s = r[31:0];
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Scoreboard: outstanding op plus expected first-valid cycle.
  typedef struct {
    bit          id;
    logic [31:0] sum;
    bit          ovf;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   mvalid = 0;
  bit   rst_prev = 0;
  bit   last_m = 1;
  bit   e0, e1, erv;

  always @(negedge clock) begin
    exp_t        t;
    logic [31:0] s;
    bit          o;
    cyc++;
    e0 = 0;
    e1 = 0;
    erv = 0;
    if (mvalid) begin
      if (reset_n && q.size() == 0) begin
        if (req0_valid && req1_valid) begin
          e0 = last_m;
          e1 = !last_m;
        end else begin
          e0 = req0_valid;
          e1 = req1_valid;
        end
      end
      chk("m_req0_ready", req0_ready, e0);
      chk("m_req1_ready", req1_ready, e1);
      erv = (q.size() != 0) && (q[0].due <= cyc);
      chk("m_rsp_valid", rsp_valid, erv);
      if (erv) begin
        chk("m_rsp_id", rsp_id, q[0].id);
        chk("m_rsp_sum", rsp_sum, q[0].sum);
        chk("m_rsp_ovf", rsp_overflow, q[0].ovf);
      end
      if (rst_prev) begin
        chk("m_rst_id", rsp_id, 0);
        chk("m_rst_sum", rsp_sum, 0);
        chk("m_rst_ovf", rsp_overflow, 0);
      end
    end
    if (!reset_n) begin
      q.delete();
      last_m = 1;
      rst_prev = 1;
      mvalid = 1;
    end else if (mvalid) begin
      rst_prev = 0;
      if (erv && rsp_ready) void'(q.pop_front());
      if ((e0 && req0_valid) || (e1 && req1_valid)) begin
        t.id = e1;
        if (e1) ref_op(req1_a, req1_b, req1_sub, s, o);
        else    ref_op(req0_a, req0_b, req0_sub, s, o);
        t.sum = s;
        t.ovf = o;
        t.due = cyc + ((e1 ? req1_sub : req0_sub) ? 3 : 2);
        last_m = e1;
        q.push_back(t);
      end
    end
  end

  task automatic set_req(input bit id, input logic [31:0] a,
                         input logic [31:0] b, input bit sub,
                         input bit v);
    if (id) begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = v;
    end
  endtask

  task automatic wait_accept(input bit id, output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (id ? req1_ready : req0_ready) got = 1;
    end
    chk("accept_seen", got, 1);
  endtask

  task automatic wait_rsp(output int n, output bit got);
    got = 0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      n++;
      if (rsp_valid) got = 1;
    end
    chk("rsp_seen", got, 1);
  endtask

  task automatic do_op(input bit id, input logic [31:0] a,
                       input logic [31:0] b, input bit sub,
                       input logic [31:0] es, input bit eo,
                       input int elat);
    bit got;
    int n;
    @(posedge clock); #1;
    set_req(id, a, b, sub, 1'b1);
    wait_accept(id, got);
    @(posedge clock); #1;
    set_req(id, a, b, sub, 1'b0);
    wait_rsp(n, got);
    if (got) begin
      chk("lit_latency", n - 1, elat);
      chk("lit_sum", rsp_sum, es);
      chk("lit_ovf", rsp_overflow, eo);
      chk("lit_id", rsp_id, id);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bit   got;
    int   n;
    logic [31:0] cap;
    int   g[$], fg[$], gt[$];

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_ovf", rsp_overflow, 0);

    do_op(0, 32'd7, 32'd5, 0, 32'd12, 0, 1);
    do_op(0, 32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 1, 1);
    do_op(1, 32'h8000_0000, 32'h8000_0000, 0, 32'd0, 1, 1);
    do_op(0, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 0, 2);
    do_op(1, 32'd0, 32'h8000_0000, 1, 32'h8000_0000, 1, 2);
    do_op(0, 32'hFFFF_FFFF, 32'h8000_0000, 1,
          32'h7FFF_FFFF, 0, 2);
    do_op(1, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, 2);

    // Stall the response while another request waits.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    set_req(1, 32'd100, 32'd1, 1, 1'b1);
    wait_accept(1, got);
    @(posedge clock); #1;
    set_req(1, 32'd100, 32'd1, 1, 1'b0);
    set_req(0, 32'd2, 32'd2, 0, 1'b1);
    wait_rsp(n, got);
    cap = rsp_sum;
    chk("stall_sum", cap, 32'd99);
    repeat (5) begin
      @(negedge clock);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_hold", rsp_sum, cap);
      chk("stall_r0", req0_ready, 0);
      chk("stall_r1", req1_ready, 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    chk("hs_valid_still", rsp_valid, 1);
    chk("hs_no_same_cycle", req0_ready, 0);
    @(negedge clock);
    chk("hs_valid_drop", rsp_valid, 0);
    chk("hs_next_accept", req0_ready, 1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clock);

    // Both requesters valid back-to-back after reset.
    pulse_reset();
    @(posedge clock); #1;
    set_req(0, 32'd1, 32'd2, 0, 1'b1);
    set_req(1, 32'd10, 32'd20, 0, 1'b1);
    f_v0 = 1'b1;
    f_v1 = 1'b1;
    for (int i = 0; i < 60 && (g.size() < 4 || fg.size() < 4);
         i++) begin
      @(negedge clock);
      if (req0_ready) begin g.push_back(0); gt.push_back(i); end
      if (req1_ready) begin g.push_back(1); gt.push_back(i); end
      if (f_r0) fg.push_back(0);
      if (f_r1) fg.push_back(1);
    end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    f_v0 = 1'b0;
    f_v1 = 1'b0;
    chk("rr_count", g.size() >= 4, 1);
    chk("fp_count", fg.size() >= 4, 1);
    if (g.size() >= 4) begin
      chk("rr_g0", g[0], 0);
      chk("rr_g1", g[1], 1);
      chk("rr_g2", g[2], 0);
      chk("rr_g3", g[3], 1);
      chk("rr_rate", gt[2] - gt[1], 3);
    end
    if (fg.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("fp_grant", fg[k], 0);
    end
    repeat (6) @(posedge clock);

    // Reset while a SUB sits in its negate pass.
    @(posedge clock); #1;
    set_req(0, 32'd9, 32'd4, 1, 1'b1);
    wait_accept(0, got);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("abort_valid", rsp_valid, 0);
      chk("abort_r0", req0_ready, 0);
    end
    chk("abort_sum", rsp_sum, 0);
    chk("abort_id", rsp_id, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    set_req(0, 32'd5, 32'd6, 0, 1'b1);
    set_req(1, 32'd7, 32'd8, 0, 1'b1);
    @(negedge clock);
    chk("post_rst_r0", req0_ready, 1);
    chk("post_rst_r1", req1_ready, 0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(n, got);
    chk("post_rst_sum", rsp_sum, 32'd11);
    repeat (4) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequencing controller that shares the single 32-bit ripple adder (`addition`) between two requesters. It arbitrates round-robin, performs ADD in one adder pass and SUB in two passes (negate, then add), and returns a registered sum plus signed-overflow flag over a valid/ready response channel. It sits between the ALU and PC/branch-target logic so that both use one adder instance.

## Interface
- `FIXED_PRIORITY`, default 0: 0 = round-robin; 1 = requester 0 always wins.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1 each  request pending.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle when valid & ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32 each  operands.
- `req0_sub`, `req1_sub`  in  1 each  0 = a+b, 1 = a−b.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_sum`  out  32  result, two's complement, wraps mod 2^32.
- `rsp_overflow`  out  1  signed overflow of the requested operation.

## Operation
- States: IDLE, NEG, ADD, RESP. Reset state IDLE.
- Grant, combinational, IDLE only:
  - One valid: that requester wins.
  - Both valid: requester ≠ `last_grant` wins (FIXED_PRIORITY=0) or requester 0 wins (FIXED_PRIORITY=1).
- `reqN_ready` = (state==IDLE) & grant==N; never high outside IDLE, never both high.
- On accept:
  - Latch a, b, sub and id into `a_q`, `b_q`, `sub_q`, `id_q`.
  - Update `last_grant`.
  - Go to NEG if sub, else ADD.
- NEG:
  - Adder inputs (~`b_q`, 32'h1).
  - Write sum back into `b_q`, discard adder overflow.
  - Set `bmin_q` = (original `b_q` == 32'h8000_0000).
  - Go to ADD.
- ADD:
  - Adder inputs (`a_q`, `b_q`).
  - Register sum into `rsp_sum`.
  - Register overflow into `rsp_overflow`: adder overflow, except when `sub_q` & `bmin_q`, where it is ~`a_q`[31].
  - Set `rsp_valid`, go to RESP.
- RESP:
  - Outputs held stable while `rsp_valid` & !`rsp_ready`.
  - On handshake edge: clear `rsp_valid`, go to IDLE.
- The adder has no carry-in; negation must use the NEG pass, not a carry input.
- Requesters hold valid and operands stable until accepted. Dropping valid before ready is legal and generates no operation.
- Reset:
  - Any cycle with `reset_n`=0 aborts an in-flight operation; no response is produced.
  - All outputs go to 0 and `last_grant` goes to 1, so requester 0 wins first.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_overflow`=0. `req*_ready`=0 during reset, then follows IDLE grant.
- ADD latency: accept at edge E0, `rsp_valid` high after E1 (1 cycle).
- SUB latency: accept at E0, `rsp_valid` high after E2 (2 cycles).
- With `rsp_ready` tied high:
  - Response handshake at the edge after `rsp_valid` rises.
  - IDLE the following cycle.
  - Peak throughput: one ADD per 3 cycles, one SUB per 4 cycles.
- No combinational path from `rsp_ready` to `req*_ready`. A new request is accepted the cycle after the response handshake, not the same cycle.

## Structure
- Shared package `adder_arb_pkg`:
  - State enum (IDLE/NEG/ADD/RESP).
  - Constants `DW`=32 and `INT_MIN`=32'h8000_0000.
  - Requester id width.
- One sub-module: a single instance of the existing `addition` (ports `in1`, `in2`, `s`, `overflow`), with inputs muxed by state.
- Arbitration logic stays inline.

## Test plan
- ADD, requester 0 only: a=7, b=5 → `rsp_sum`=12, ovf=0, `rsp_id`=0, `rsp_valid` 1 cycle after accept.
- ADD overflow: a=32'h7FFF_FFFF, b=1 → sum=32'h8000_0000, ovf=1. Also a=b=32'h8000_0000 → sum=0, ovf=1.
- SUB, including the INT_MIN corner:
  - a=3, b=5 → sum=32'hFFFF_FFFE, ovf=0, latency 2.
  - a=0, b=32'h8000_0000 → sum=32'h8000_0000, ovf=1.
  - a=32'hFFFF_FFFF, b=32'h8000_0000 → sum=32'h7FFF_FFFF, ovf=0.
- Both valid continuously, `rsp_ready`=1 → grants alternate 0,1,0,1; with FIXED_PRIORITY=1 → all grants to 0.
- `rsp_ready` low 5 cycles in RESP → `rsp_*` stable, both `req*_ready`=0. Raising `rsp_ready` → `rsp_valid` drops next edge, IDLE after.
- Assert `reset_n`=0 during a SUB in NEG → no `rsp_valid`, outputs 0. After release, simultaneous requests → requester 0 granted first.
